zigbee_top: RTL and testbench

ZIGBEE_TOP -- requirements
Module: zigbee_top

---
 rtl/zigbee_top_if.sv | 36 +++
 rtl/zigbee_top.sv | 232 +++++++++++++++++++++++
 tb/tb_zigbee_top.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/zigbee_top_if.sv
// Control/data bundle between the pin-level wrapper and the FIFO/ALU core.
interface zigbee_top_if;
    logic [3:0] in_data;
    logic       rd_en;
    logic       wr_en;
    logic       xfer_en;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       sel_payload;
    logic [1:0] sel_mux10;
    logic [1:0] sel_mux9;
    logic       sel_mux16_lo;
    logic       sel_mux16_hi;
    logic [2:0] sel_mux15;
    logic       sel_dest;
    logic [3:0] out_mux9;
    logic [3:0] out_mux10;
    logic       out_mux15;
    logic       out_mux16;

    modport master (
        output in_data, rd_en, wr_en, xfer_en, op_a, op_b, sel_a, sel_b,
               sel_payload, sel_mux10, sel_mux9, sel_mux16_lo, sel_mux16_hi,
               sel_mux15, sel_dest,
        input  out_mux9, out_mux10, out_mux15, out_mux16
    );

    modport slave (
        input  in_data, rd_en, wr_en, xfer_en, op_a, op_b, sel_a, sel_b,
               sel_payload, sel_mux10, sel_mux9, sel_mux16_lo, sel_mux16_hi,
               sel_mux15, sel_dest,
        output out_mux9, out_mux10, out_mux15, out_mux16
    );
endinterface

// File: rtl/zigbee_top.sv
// Input FIFO -> two-stage 4-bit ALU -> output FIFO or hold register,
// with selectable monitor muxes. Pin-level wrapper plus core.
module zigbee_core #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    zigbee_top_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Shared opcode table for both ALU stages
    function automatic logic [3:0] alu(input logic [2:0] op,
                                       input logic [3:0] w,
                                       input logic [3:0] k);
        logic [3:0] res;
        case (op)
            3'd0:    res = w;
            3'd1:    res = ~w;
            3'd2:    res = {w[0], w[1], w[2], w[3]};
            3'd3:    res = {w[2:0], w[3]};
            3'd4:    res = {w[0], w[3:1]};
            3'd5:    res = w ^ k;
            3'd6:    res = w + k;
            default: res = w - k;
        endcase
        return res;
    endfunction

    logic [3:0]       if_mem_q [FIFO_DEPTH];
    logic [3:0]       if_mem_d [FIFO_DEPTH];
    logic [3:0]       of_mem_q [FIFO_DEPTH];
    logic [3:0]       of_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] if_wp_q, if_wp_d, if_rp_q, if_rp_d;
    logic [PTR_W-1:0] of_wp_q, of_wp_d, of_rp_q, of_rp_d;
    logic [CNT_W-1:0] if_cnt_q, if_cnt_d, of_cnt_q, of_cnt_d;
    logic [3:0]       r_q, r_d, ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
    logic             rv_q, rv_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             xfer_pulse_q, xfer_pulse_d;

    logic             if_full_c, if_empty_c, of_full_c, of_empty_c;
    logic             xfer_c, if_wr_c, of_push_c, of_pop_c;
    logic [3:0]       w_c, a_c, b_c, p_c;

    // Handshake qualification and datapath
    always_comb begin
        if_full_c  = (if_cnt_q == DEPTH_C);
        if_empty_c = (if_cnt_q == '0);
        of_full_c  = (of_cnt_q == DEPTH_C);
        of_empty_c = (of_cnt_q == '0);
        xfer_c     = bus.xfer_en && !if_empty_c && (bus.sel_dest || !of_full_c);
        if_wr_c    = bus.wr_en && (!if_full_c || xfer_c);
        of_push_c  = xfer_c && !bus.sel_dest;
        of_pop_c   = bus.rd_en && !of_empty_c;
        w_c        = if_mem_q[if_rp_q];
        a_c        = alu(bus.sel_a, w_c, bus.op_a);
        b_c        = alu(bus.sel_b, a_c, bus.op_b);
        p_c        = bus.sel_payload ? w_c : b_c;
    end

    always_comb begin
        if_mem_d     = if_mem_q;
        of_mem_d     = of_mem_q;
        if_wp_d      = if_wp_q;
        if_rp_d      = if_rp_q;
        of_wp_d      = of_wp_q;
        of_rp_d      = of_rp_q;
        if_cnt_d     = if_cnt_q;
        of_cnt_d     = of_cnt_q;
        r_d          = r_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        rd_d         = rd_q;
        rv_d         = 1'b0;
        xfer_pulse_d = xfer_c;
        ovf_d        = ovf_q | (bus.wr_en & ~if_wr_c);
        unf_d        = unf_q | (bus.rd_en & of_empty_c);

        if (if_wr_c) begin
            if_mem_d[if_wp_q] = bus.in_data;
            if_wp_d           = if_wp_q + PTR_W'(1);
        end
        if (xfer_c) begin
            if_rp_d = if_rp_q + PTR_W'(1);
            ra_d    = a_c;
            rb_d    = b_c;
            if (bus.sel_dest) r_d = p_c;
        end
        if (of_push_c) begin
            of_mem_d[of_wp_q] = p_c;
            of_wp_d           = of_wp_q + PTR_W'(1);
        end
        if (of_pop_c) begin
            rd_d    = of_mem_q[of_rp_q];
            rv_d    = 1'b1;
            of_rp_d = of_rp_q + PTR_W'(1);
        end

        // Simultaneous push and pop leave the count unchanged
        if (if_wr_c && !xfer_c)      if_cnt_d = if_cnt_q + CNT_W'(1);
        else if (!if_wr_c && xfer_c) if_cnt_d = if_cnt_q - CNT_W'(1);
        if (of_push_c && !of_pop_c)      of_cnt_d = of_cnt_q + CNT_W'(1);
        else if (!of_push_c && of_pop_c) of_cnt_d = of_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_mem_q     <= '{default: '0};
            of_mem_q     <= '{default: '0};
            if_wp_q      <= '0;
            if_rp_q      <= '0;
            of_wp_q      <= '0;
            of_rp_q      <= '0;
            if_cnt_q     <= '0;
            of_cnt_q     <= '0;
            r_q          <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            rd_q         <= '0;
            rv_q         <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            xfer_pulse_q <= 1'b0;
        end else begin
            if_mem_q     <= if_mem_d;
            of_mem_q     <= of_mem_d;
            if_wp_q      <= if_wp_d;
            if_rp_q      <= if_rp_d;
            of_wp_q      <= of_wp_d;
            of_rp_q      <= of_rp_d;
            if_cnt_q     <= if_cnt_d;
            of_cnt_q     <= of_cnt_d;
            r_q          <= r_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            rd_q         <= rd_d;
            rv_q         <= rv_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            xfer_pulse_q <= xfer_pulse_d;
        end
    end

    // Monitor muxes over registered state (sel6=2/3 tap live inputs and payload)
    always_comb begin
        case (bus.sel_mux9)
            2'd0:    bus.out_mux9 = rd_q;
            2'd1:    bus.out_mux9 = r_q;
            2'd2:    bus.out_mux9 = if_cnt_q;
            default: bus.out_mux9 = of_cnt_q;
        endcase
        case (bus.sel_mux10)
            2'd0:    bus.out_mux10 = ra_q;
            2'd1:    bus.out_mux10 = rb_q;
            2'd2:    bus.out_mux10 = {bus.xfer_en, bus.wr_en, of_empty_c, of_full_c};
            default: bus.out_mux10 = p_c;
        endcase
        case (bus.sel_mux15)
            3'd0:    bus.out_mux15 = if_full_c;
            3'd1:    bus.out_mux15 = if_empty_c;
            3'd2:    bus.out_mux15 = of_full_c;
            3'd3:    bus.out_mux15 = of_empty_c;
            3'd4:    bus.out_mux15 = ^rd_q;
            3'd5:    bus.out_mux15 = rv_q;
            3'd6:    bus.out_mux15 = r_q[3];
            default: bus.out_mux15 = 1'b0;
        endcase
        case ({bus.sel_mux16_hi, bus.sel_mux16_lo})
            2'b00:   bus.out_mux16 = ovf_q;
            2'b01:   bus.out_mux16 = unf_q;
            2'b10:   bus.out_mux16 = rv_q;
            default: bus.out_mux16 = xfer_pulse_q;
        endcase
    end
endmodule

module zigbee_top #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic [3:0] in_inFIFO_inData,
    input  logic       in_outFIFO_inReadEnable,
    input  logic       in_DEMUX_inDEMUX1,
    input  logic       in_DEMUX_inDEMUX2,
    input  logic [3:0] in_DEMUX_inDEMUX17,
    input  logic [3:0] in_DEMUX_inDEMUX18,
    input  logic [2:0] in_DEMUX_inSEL1,
    input  logic [2:0] in_DEMUX_inSEL2,
    input  logic       in_MUX_inSEL3,
    input  logic [1:0] in_MUX_inSEL6,
    input  logic [1:0] in_MUX_inSEL9,
    input  logic       in_MUX_inSEL11,
    input  logic       in_MUX_inSEL12,
    input  logic [2:0] in_MUX_inSEL15,
    input  logic       in_DEMUX_inSEL17,
    output logic [3:0] out_MUX_outMUX9,
    output logic [3:0] out_MUX_outMUX10,
    output logic       out_MUX_outMUX15,
    output logic       out_MUX_outMUX16
);
    zigbee_top_if u_bus ();

    assign u_bus.in_data      = in_inFIFO_inData;
    assign u_bus.rd_en        = in_outFIFO_inReadEnable;
    assign u_bus.wr_en        = in_DEMUX_inDEMUX1;
    assign u_bus.xfer_en      = in_DEMUX_inDEMUX2;
    assign u_bus.op_a         = in_DEMUX_inDEMUX17;
    assign u_bus.op_b         = in_DEMUX_inDEMUX18;
    assign u_bus.sel_a        = in_DEMUX_inSEL1;
    assign u_bus.sel_b        = in_DEMUX_inSEL2;
    assign u_bus.sel_payload  = in_MUX_inSEL3;
    assign u_bus.sel_mux10    = in_MUX_inSEL6;
    assign u_bus.sel_mux9     = in_MUX_inSEL9;
    assign u_bus.sel_mux16_lo = in_MUX_inSEL11;
    assign u_bus.sel_mux16_hi = in_MUX_inSEL12;
    assign u_bus.sel_mux15    = in_MUX_inSEL15;
    assign u_bus.sel_dest     = in_DEMUX_inSEL17;

    assign out_MUX_outMUX9    = u_bus.out_mux9;
    assign out_MUX_outMUX10   = u_bus.out_mux10;
    assign out_MUX_outMUX15   = u_bus.out_mux15;
    assign out_MUX_outMUX16   = u_bus.out_mux16;

    zigbee_core #(.FIFO_DEPTH(FIFO_DEPTH)) u_core (
        .clk   (inClock),
        .rst_n (inReset),
        .bus   (u_bus.slave)
    );
endmodule

// File: tb/tb_zigbee_top.sv
// Directed-vector bench for zigbee_top with hand-computed expectations.
module tb_zigbee_top;
    logic inClock;
    logic inReset;
    int   n_tests;
    int   n_fail;

    zigbee_top_if bus ();

    zigbee_top #(.FIFO_DEPTH(8)) dut (
        .inClock                 (inClock),
        .inReset                 (inReset),
        .in_inFIFO_inData        (bus.in_data),
        .in_outFIFO_inReadEnable (bus.rd_en),
        .in_DEMUX_inDEMUX1       (bus.wr_en),
        .in_DEMUX_inDEMUX2       (bus.xfer_en),
        .in_DEMUX_inDEMUX17      (bus.op_a),
        .in_DEMUX_inDEMUX18      (bus.op_b),
        .in_DEMUX_inSEL1         (bus.sel_a),
        .in_DEMUX_inSEL2         (bus.sel_b),
        .in_MUX_inSEL3           (bus.sel_payload),
        .in_MUX_inSEL6           (bus.sel_mux10),
        .in_MUX_inSEL9           (bus.sel_mux9),
        .in_MUX_inSEL11          (bus.sel_mux16_lo),
        .in_MUX_inSEL12          (bus.sel_mux16_hi),
        .in_MUX_inSEL15          (bus.sel_mux15),
        .in_DEMUX_inSEL17        (bus.sel_dest),
        .out_MUX_outMUX9         (bus.out_mux9),
        .out_MUX_outMUX10        (bus.out_mux10),
        .out_MUX_outMUX15        (bus.out_mux15),
        .out_MUX_outMUX16        (bus.out_mux16)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClock);
        #1;
    endtask

    task automatic clear_ctl();
        bus.in_data = '0;  bus.rd_en = 0;  bus.wr_en = 0;  bus.xfer_en = 0;
        bus.op_a = '0;     bus.op_b = '0;  bus.sel_a = '0; bus.sel_b = '0;
        bus.sel_payload = 0; bus.sel_mux10 = '0; bus.sel_mux9 = '0;
        bus.sel_mux16_lo = 0; bus.sel_mux16_hi = 0; bus.sel_mux15 = '0;
        bus.sel_dest = 0;
    endtask

    task automatic do_reset(input int cycles);
        clear_ctl();
        inReset = 1'b0;
        repeat (cycles) tick();
        inReset = 1'b1;
    endtask

    task automatic sel16(input logic [1:0] s);
        {bus.sel_mux16_hi, bus.sel_mux16_lo} = s;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        inReset = 1'b0;
        clear_ctl();

        // Reset state: all outputs zero, IF empty visible on flag monitor
        do_reset(5);
        check("rst_mux9", bus.out_mux9, 4'b0000);
        check("rst_mux10", bus.out_mux10, 4'b0000);
        check("rst_mux15", {3'b0, bus.out_mux15}, 4'b0000);
        check("rst_mux16", {3'b0, bus.out_mux16}, 4'b0000);
        bus.sel_mux15 = 3'd1; #1;
        check("rst_if_empty", {3'b0, bus.out_mux15}, 4'b0001);
        bus.sel_mux15 = 3'd0;

        // Streaming latency with all enables held
        bus.in_data = 4'b1101; bus.wr_en = 1; bus.xfer_en = 1; bus.rd_en = 1;
        tick();
        check("lat_e1_rd", bus.out_mux9, 4'b0000);
        sel16(2'b01);
        check("lat_unf", {3'b0, bus.out_mux16}, 4'b0001);
        sel16(2'b00);
        tick();
        check("lat_e2_rd", bus.out_mux9, 4'b0000);
        tick();
        check("lat_e3_rd", bus.out_mux9, 4'b1101);
        bus.sel_mux15 = 3'd5; #1;
        check("lat_rv", {3'b0, bus.out_mux15}, 4'b0001);
        bus.sel_mux15 = 3'd0;
        sel16(2'b11);
        check("lat_pulse", {3'b0, bus.out_mux16}, 4'b0001);
        sel16(2'b00);
        tick();
        check("lat_e4_rd", bus.out_mux9, 4'b1101);
        bus.sel_mux9 = 2'd2; #1;
        check("lat_if_cnt", bus.out_mux9, 4'd1);
        bus.sel_mux9 = 2'd0;

        // Two-stage ALU: ~1101 = 0010, +0011 = 0101
        do_reset(1);
        bus.sel_a = 3'd1; bus.sel_b = 3'd6; bus.op_b = 4'b0011;
        bus.in_data = 4'b1101; bus.wr_en = 1;
        tick();
        bus.wr_en = 0;
        bus.sel_mux10 = 2'd3; #1;
        check("alu_p_comb", bus.out_mux10, 4'b0101);
        bus.xfer_en = 1;
        tick();
        bus.xfer_en = 0;
        bus.sel_mux10 = 2'd0; #1;
        check("alu_ra", bus.out_mux10, 4'b0010);
        bus.sel_mux10 = 2'd1; #1;
        check("alu_rb", bus.out_mux10, 4'b0101);
        bus.sel_mux9 = 2'd3; #1;
        check("alu_of_cnt", bus.out_mux9, 4'd1);
        bus.rd_en = 1;
        tick();
        bus.rd_en = 0;
        bus.sel_mux9 = 2'd0; #1;
        check("alu_rd", bus.out_mux9, 4'b0101);
        bus.sel_mux15 = 3'd4; #1;
        check("alu_rd_xor", {3'b0, bus.out_mux15}, 4'b0000);

        // Bit-reverse then XOR: rev(0011)=1100, ^1010 = 0110
        bus.sel_a = 3'd2; bus.sel_b = 3'd5; bus.op_b = 4'b1010;
        bus.in_data = 4'b0011; bus.wr_en = 1;
        tick();
        bus.wr_en = 0;
        bus.sel_mux10 = 2'd3; #1;
        check("rev_xor_p", bus.out_mux10, 4'b0110);
        bus.sel_payload = 1; #1;
        check("raw_p", bus.out_mux10, 4'b0011);
        bus.sel_payload = 0;
        bus.sel_mux10 = 2'd2; #1;
        check("status_word", bus.out_mux10, 4'b0010);
        bus.sel_mux15 = 3'd3; #1;
        check("of_empty", {3'b0, bus.out_mux15}, 4'b0001);

        // Fill IF to depth, then one extra write is dropped
        do_reset(1);
        bus.wr_en = 1;
        bus.sel_mux9 = 2'd2;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 4'(i);
            tick();
        end
        check("fill_cnt8", bus.out_mux9, 4'd8);
        check("fill_no_ovf", {3'b0, bus.out_mux16}, 4'b0000);
        bus.in_data = 4'hF;
        tick();
        check("ovf_cnt8", bus.out_mux9, 4'd8);
        check("ovf_flag", {3'b0, bus.out_mux16}, 4'b0001);
        bus.sel_mux15 = 3'd0; #1;
        check("if_full", {3'b0, bus.out_mux15}, 4'b0001);
        // Write into a full IF is accepted when a transfer pops it
        bus.xfer_en = 1;
        tick();
        bus.xfer_en = 0; bus.wr_en = 0;
        check("full_wr_xfer_if", bus.out_mux9, 4'd8);
        bus.sel_mux9 = 2'd3; #1;
        check("full_wr_xfer_of", bus.out_mux9, 4'd1);

        // Route raw word to hold register R
        do_reset(1);
        bus.sel_dest = 1; bus.sel_payload = 1;
        bus.in_data = 4'b1011; bus.wr_en = 1;
        tick();
        bus.wr_en = 0; bus.xfer_en = 1;
        tick();
        bus.xfer_en = 0;
        bus.sel_mux9 = 2'd1; #1;
        check("hold_r", bus.out_mux9, 4'b1011);
        bus.sel_mux9 = 2'd3; #1;
        check("hold_of_cnt", bus.out_mux9, 4'd0);
        bus.sel_mux15 = 3'd6; #1;
        check("hold_r3", {3'b0, bus.out_mux15}, 4'b0001);
        sel16(2'b11);
        check("hold_pulse", {3'b0, bus.out_mux16}, 4'b0001);

        // Reset mid-stream clears everything on that edge
        bus.in_data = 4'b0110; bus.wr_en = 1; bus.xfer_en = 1; bus.rd_en = 1;
        inReset = 1'b0;
        tick();
        check("mid_rst_pulse", {3'b0, bus.out_mux16}, 4'b0000);
        bus.sel_mux9 = 2'd1; #1;
        check("mid_rst_r", bus.out_mux9, 4'b0000);
        bus.sel_mux9 = 2'd2; #1;
        check("mid_rst_if_cnt", bus.out_mux9, 4'd0);
        bus.sel_mux9 = 2'd3; #1;
        check("mid_rst_of_cnt", bus.out_mux9, 4'd0);
        sel16(2'b01);
        check("mid_rst_unf", {3'b0, bus.out_mux16}, 4'b0000);

        clear_ctl();
        inReset = 1'b1;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
